nrisc_fetch: RTL and testbench



---
 rtl/nrisc_fetch_pkg.sv | 16 +
 rtl/nrisc_fetch_if.sv | 28 ++
 rtl/nrisc_fetch_queue.sv | 56 +++++
 rtl/nrisc_fetch.sv | 77 +++++++
 tb/tb_nrisc_fetch.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/nrisc_fetch_pkg.sv
// Shared widths, reset constant and the prefetch-queue entry type for the
// nRisc fetch stage.
package nrisc_fetch_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 8;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 8'h00;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetchEntry_t;

endpackage

// File: rtl/nrisc_fetch_if.sv
// Bus bundle of the fetch stage: instruction-memory read port plus the
// valid/ready instruction handshake and redirect request from the core.
interface nrisc_fetch_if;
  import nrisc_fetch_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic [INSTR_W-1:0] instrucao;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_valid;
  logic               instr_ready;

  // Fetch stage side.
  modport master (
    output imem_req, imem_addr, instrucao, instr_pc, instr_valid,
    input  imem_data, redirect, redirect_pc, instr_ready
  );

  // Memory / core side.
  modport slave (
    input  imem_req, imem_addr, instrucao, instr_pc, instr_valid,
    output imem_data, redirect, redirect_pc, instr_ready
  );

endinterface

// File: rtl/nrisc_fetch_queue.sv
// Small prefetch FIFO. Entry 0 is always the head, so the head is read
// straight out of a register; slots beyond the occupancy are kept at zero so
// an empty queue presents an all-zero head without extra gating.
module nrisc_fetch_queue
  import nrisc_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = IDX_W + 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              flush,
  input  logic              push,
  input  fetchEntry_t       pushEntry,
  input  logic              pop,
  output fetchEntry_t       head,
  output logic              headValid,
  output logic [CNT_W-1:0]  occ
);

  fetchEntry_t      entries [DEPTH];
  logic [CNT_W-1:0] occCount;
  logic [CNT_W-1:0] wrSlot;
  logic [IDX_W-1:0] wrIdx;
  logic             doPop;

  // Write slot: first free entry, one lower when the head shifts out this cycle.
  always_comb begin
    doPop  = pop && (occCount != '0);
    wrSlot = doPop ? occCount - 1'b1 : occCount;
    wrIdx  = wrSlot[IDX_W-1:0];
  end

  // Shift-down FIFO storage with flush; a push in the same cycle overrides the shifted slot.
  // NOTE: the entries are reset and refilled with zero on pop because the
  // empty-queue head must read as zero; a plain FIFO array would not need it.
  always_ff @(posedge CLK) begin
    if (RESET || flush) begin
      occCount <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      if (doPop) begin
        for (int i = 0; i < DEPTH - 1; i++) entries[i] <= entries[i+1];
        entries[DEPTH-1] <= '0;
      end
      if (push) entries[wrIdx] <= pushEntry;
      occCount <= occCount + CNT_W'(push) - CNT_W'(doPop);
    end
  end

  assign head      = entries[0];
  assign headValid = (occCount != '0);
  assign occ       = occCount;

endmodule

// File: rtl/nrisc_fetch.sv
// nRisc instruction fetch stage: owns the fetch PC, issues one-cycle-latency
// reads to instruction memory, buffers returns in the prefetch queue and
// restarts on core redirects. Requests are credit-limited so the queue can
// never overflow (occupancy + in-flight read never exceeds DEPTH).
module nrisc_fetch
  import nrisc_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  nrisc_fetch_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PC_W-1:0]  fpc;
  logic [PC_W-1:0]  inflightPc;
  logic             inflight;
  logic             req;
  logic             pop;
  logic             push;
  logic [CNT_W:0]   used;
  logic [CNT_W-1:0] occ;
  logic             headValid;
  fetchEntry_t      head;
  fetchEntry_t      pushEntry;

  // Credit check: a pop this cycle frees a slot, so fetch resumes the same cycle ready returns.
  always_comb begin
    pop       = headValid && bus.instr_ready;
    used      = {1'b0, occ} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    req       = !RESET && !bus.redirect && (used < (CNT_W+1)'(DEPTH));
    push      = inflight && !bus.redirect;
    pushEntry = '{instr: bus.imem_data, pc: inflightPc};
  end

  // Fetch PC and in-flight read tracking; reset beats redirect, redirect drops the in-flight read.
  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fpc        <= RESET_PC;
      inflight   <= 1'b0;
      inflightPc <= '0;
    end else if (bus.redirect) begin
      fpc      <= bus.redirect_pc;
      inflight <= 1'b0;
    end else if (req) begin
      fpc        <= fpc + 1'b1;
      inflight   <= 1'b1;
      inflightPc <= fpc;
    end else begin
      inflight <= 1'b0;
    end
  end

  nrisc_fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .CLK       (CLK),
    .RESET     (RESET),
    .flush     (bus.redirect),
    .push      (push),
    .pushEntry (pushEntry),
    .pop       (pop),
    .head      (head),
    .headValid (headValid),
    .occ       (occ)
  );

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fpc;
  assign bus.instrucao   = head.instr;
  assign bus.instr_pc    = head.pc;
  assign bus.instr_valid = headValid;

endmodule

// File: tb/tb_nrisc_fetch.sv
// Directed bench for nrisc_fetch: a per-cycle vector table covering cold
// start, back-pressure, redirects (with in-flight read and with concurrent
// pop) and PC wrap, followed by hand-written reset sequences.
module tb_nrisc_fetch;

  logic       CLK;
  logic       RESET;
  logic [7:0] imemData;

  nrisc_fetch_if bus ();

  nrisc_fetch #(.RESET_PC(8'h00), .DEPTH(2)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  assign bus.imem_data = imemData;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous instruction memory: data = addr ^ A5 one cycle after a request.
  always @(posedge CLK) begin
    if (bus.imem_req) imemData <= bus.imem_addr ^ 8'hA5;
    else              imemData <= 8'h3C;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       ready;
    logic       redir;
    logic [7:0] rpc;
    logic       expReq;
    logic [7:0] expAddr;
    logic       expValid;
    logic [7:0] expPc;
  } vec_t;

  vec_t vecs[$];
  int   passCount  = 0;
  int   checkCount = 0;

  function automatic vec_t mk(input logic rdy, input logic rd, input logic [7:0] rpc,
                              input logic rq, input logic [7:0] addr,
                              input logic vld, input logic [7:0] pc);
    vec_t v;
    v.ready = rdy; v.redir = rd; v.rpc = rpc;
    v.expReq = rq; v.expAddr = addr; v.expValid = vld; v.expPc = pc;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("FAIL %s: got %02h expected %02h", name, got, exp);
  endtask

  // Compare every output against one expected record (instr derived from pc).
  task automatic checkAll(input string tag, input logic rq, input logic [7:0] addr,
                          input logic vld, input logic [7:0] pc);
    logic [7:0] expInstr;
    logic [7:0] expPcOut;
    expInstr = vld ? (pc ^ 8'hA5) : 8'h00;
    expPcOut = vld ? pc : 8'h00;
    check({tag, " imem_req"},    {7'd0, bus.imem_req},    {7'd0, rq});
    check({tag, " imem_addr"},   bus.imem_addr,           addr);
    check({tag, " instr_valid"}, {7'd0, bus.instr_valid}, {7'd0, vld});
    check({tag, " instr_pc"},    bus.instr_pc,            expPcOut);
    check({tag, " instrucao"},   bus.instrucao,           expInstr);
  endtask

  task automatic drive(input logic rst, input logic rdy, input logic rd, input logic [7:0] rpc);
    @(negedge CLK);
    RESET           = rst;
    bus.instr_ready = rdy;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    #1;
  endtask

  initial begin
    RESET           = 1'b1;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 8'h00;

    // Cold start, ready held high.
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 8'h00));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'h00));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 8'h01));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 8'h02));
    // Ready low for 6 cycles: credit exhausted, head holds at 03.
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h05, 1'b1, 8'h03));
    // Resume: request in the same cycle ready returns, no loss or duplicate.
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h05, 1'b1, 8'h03));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h06, 1'b1, 8'h04));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h07, 1'b1, 8'h05));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h08, 1'b1, 8'h06));
    // Redirect to 40 with credit full and a read in flight.
    vecs.push_back(mk(1'b0, 1'b1, 8'h40, 1'b0, 8'h09, 1'b1, 8'h07));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0, 8'h00));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0, 8'h00));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h42, 1'b1, 8'h40));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h43, 1'b1, 8'h41));
    // Redirect to FE with a concurrent pop, then wrap FE,FF,00,01.
    vecs.push_back(mk(1'b1, 1'b1, 8'hFE, 1'b0, 8'h44, 1'b1, 8'h42));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'hFE, 1'b0, 8'h00));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 8'h00));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'hFE));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 8'hFF));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'h00));
    vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 8'h01));

    // Reset state.
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    checkAll("reset", 1'b0, 8'h00, 1'b0, 8'h00);

    // Table: row k is the k-th cycle after reset release.
    foreach (vecs[k]) begin
      drive(1'b0, vecs[k].ready, vecs[k].redir, vecs[k].rpc);
      checkAll($sformatf("row%0d", k + 1), vecs[k].expReq, vecs[k].expAddr,
               vecs[k].expValid, vecs[k].expPc);
    end

    // RESET and redirect together mid-stream: reset wins, fetch restarts at RESET_PC.
    drive(1'b1, 1'b1, 1'b1, 8'h80);
    check("rst+redir imem_req", {7'd0, bus.imem_req}, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    checkAll("rst+redir c1", 1'b1, 8'h00, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    checkAll("rst+redir c2", 1'b1, 8'h01, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    checkAll("rst+redir c3", 1'b1, 8'h02, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    checkAll("rst+redir c4", 1'b1, 8'h03, 1'b1, 8'h01);

    // Plain mid-stream reset with ready low: in-flight data discarded.
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    checkAll("midrst c1", 1'b1, 8'h00, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    checkAll("midrst c2", 1'b1, 8'h01, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    checkAll("midrst c3", 1'b0, 8'h02, 1'b1, 8'h00);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
